// File: rtl/hic_pkg.sv
// Shared definitions for the HIC event capture FIFO.
package hic_pkg;

  // Controller states: IDLE = not capturing, RUN = capturing, HALT = stalled on overflow
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } hic_state_e;

  // Mode values echoed by the upstream counter stage
  localparam logic [1:0] MO_HOLD = 2'd0;
  localparam logic [1:0] MO_UP   = 2'd1;
  localparam logic [1:0] MO_DOWN = 2'd2;
  localparam logic [1:0] MO_LOAD = 2'd3;

  localparam int HIC_DW = 8;
  localparam int HIC_EW = HIC_DW + 2;

  // A stored entry is the mode echo on top of the counter value
  function automatic int entry_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/hic_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module hic_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the entry at the write pointer; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read is combinational so a pop registers the pre-edge entry, even when the
  // same slot is overwritten by a simultaneous push on a full FIFO.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hic_event_fifo.sv
// Event capture FIFO behind the HIC counter stage.
// state | meaning
// IDLE  | not armed; events ignored, host may still drain
// RUN   | armed; each event pushes {mo, fout}
// HALT  | overflowed while armed; events counted as drops until space frees
module hic_event_fifo
  import hic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = HIC_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic [DW-1:0]           fout,
  input  logic                    cout,
  input  logic [1:0]              mo,
  input  logic                    rd_req,
  output logic [DW+1:0]           rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              drop_cnt,
  output logic                    halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_width(DW);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  hic_state_e    r_state;
  hic_state_e    w_state_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [1:0]    r_mo_q;
  logic [7:0]    r_drop_cnt;
  logic [EW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic          w_event;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_mem_rdata;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_event = cout | (mo != r_mo_q);
  // A pop on an empty FIFO is ignored even when a push lands on the same edge
  assign w_pop   = rd_req & ~w_empty;

  // Next-state, push and drop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_event) begin
          if (!w_full || w_pop) w_push = 1'b1;
          else                  w_drop = 1'b1;
        end
        if (!arm)        w_state_nxt = IDLE;
        else if (w_drop) w_state_nxt = HALT;
      end
      HALT: begin
        w_drop = w_event;
        if (!arm)        w_state_nxt = IDLE;
        else if (!w_full) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and registered mode echo used for change detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mo_q  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_mo_q  <= mo;
    end
  end

  // Pointers and occupancy; full/empty come from the level, not the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered read path; data holds when no pop occurs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= w_mem_rdata;
    end
  end

  // Saturating lost-event counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  hic_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({mo, fout}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign level    = r_level;
  assign drop_cnt = r_drop_cnt;
  assign halted   = (r_state == HALT);

endmodule

// File: tb/tb_hic_event_fifo.sv
// Scoreboard bench for hic_event_fifo with a queue-based reference model.
module tb_hic_event_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic [DW-1:0] fout = '0;
  logic          cout = 1'b0;
  logic [1:0]    mo = 2'b00;
  logic          rd_req = 1'b0;
  logic [DW+1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [3:0]    level;
  logic [7:0]    drop_cnt;
  logic          halted;

  hic_event_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .fout     (fout),
    .cout     (cout),
    .mo       (mo),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .drop_cnt (drop_cnt),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: capture mode, stored entries, pending pops, drops
  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
  mstate_t     m_st   = M_IDLE;
  logic [9:0]  q[$];
  logic [9:0]  exp_q[$];
  logic [1:0]  m_moq  = 2'b00;
  int          m_drop = 0;
  logic [9:0]  m_last = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st   = M_IDLE;
    q.delete();
    exp_q.delete();
    m_moq  = 2'b00;
    m_drop = 0;
    m_last = '0;
  endfunction

  // Applies one clock edge worth of the capture rules to the model.
  function automatic void model_step();
    bit      ev, pop, push, drop;
    mstate_t nx;
    ev   = cout || (mo != m_moq);
    pop  = rd_req && (q.size() != 0);
    push = 0;
    drop = 0;
    nx   = m_st;
    case (m_st)
      M_IDLE: if (arm) nx = M_RUN;
      M_RUN: begin
        if (ev) begin
          if (q.size() < DEPTH || pop) push = 1;
          else                         drop = 1;
        end
        nx = !arm ? M_IDLE : (drop ? M_HALT : M_RUN);
      end
      M_HALT: begin
        drop = ev;
        nx = !arm ? M_IDLE : ((q.size() < DEPTH) ? M_RUN : M_HALT);
      end
      default: nx = M_IDLE;
    endcase
    if (pop)  exp_q.push_back(q.pop_front());
    if (push) q.push_back({mo, fout});
    if (drop && m_drop < 255) m_drop++;
    m_moq = mo;
    m_st  = nx;
  endfunction

  // Drive one cycle from a falling edge, then check status on the next falling edge.
  task automatic cycle(input logic a, input logic [7:0] f, input logic c,
                       input logic [1:0] m, input logic r);
    arm = a; fout = f; cout = c; mo = m; rd_req = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("level",    32'(level),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("halted",   32'(halted),   32'(m_st == M_HALT));
  endtask

  // Monitor: after every rising edge, compare the read port against popped expectations.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) m_last = exp_q.pop_front();
      chk("rd_data", 32'(rd_data), 32'(m_last));
    end
  end

  initial begin
    logic [1:0] rm;
    int         rd_pct;

    // Reset state
    arm = 1'b1; mo = 2'd3;
    #2;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_halted", 32'(halted), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // First event after reset: mo=3 seen in IDLE is ignored, mo 3->1 in RUN is stored
    cycle(1, 8'hAA, 0, 2'd3, 0);
    cycle(1, 8'h55, 0, 2'd1, 0);
    chk("first_level", 32'(level), 1);
    cycle(1, 8'h00, 0, 2'd1, 1);

    // Fill to full, then drain in order
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h10 + i), 1, 2'd1, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 8);
    for (int i = 0; i < 8; i++) cycle(1, 8'h00, 0, 2'd1, 1);
    chk("drain_empty", 32'(empty), 1);

    // Overflow into HALT, recover after one pop
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h20 + i), 1, 2'd1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'hE0 + i), 1, 2'd1, 0);
    chk("ovf_halted", 32'(halted), 1);
    chk("ovf_drop", 32'(drop_cnt), 3);
    cycle(1, 8'h00, 0, 2'd1, 1);
    cycle(1, 8'h00, 0, 2'd1, 0);
    chk("resume_halted", 32'(halted), 0);
    cycle(1, 8'h77, 1, 2'd1, 0);
    chk("resume_level", 32'(level), 8);

    // Push and pop together while full
    cycle(1, 8'h88, 1, 2'd1, 1);
    chk("pp_full_level", 32'(level), 8);
    chk("pp_full_drop", 32'(drop_cnt), 3);

    // Drain, pop while empty, then push and pop together while empty
    for (int i = 0; i < 8; i++) cycle(1, 8'h00, 0, 2'd1, 1);
    cycle(1, 8'h00, 0, 2'd1, 1);
    cycle(1, 8'h00, 0, 2'd1, 1);
    chk("pop_empty_valid", 32'(rd_valid), 0);
    cycle(1, 8'h99, 1, 2'd1, 1);
    chk("pp_empty_level", 32'(level), 1);

    // Reach level 5, then reset asynchronously between edges
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h30 + i), 1, 2'd1, 0);
    chk("pre_rst_level", 32'(level), 5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_drop", 32'(drop_cnt), 0);
    chk("arst_halted", 32'(halted), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Disarmed: events ignored, no drops
    for (int i = 0; i < 10; i++) cycle(0, 8'(i), 1'(i % 2 == 0), 2'd0, 1'(i % 3 == 0));
    chk("idle_level", 32'(level), 0);
    chk("idle_drop", 32'(drop_cnt), 0);

    // Saturate the drop counter
    cycle(1, 8'h00, 0, 2'd0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h40 + i), 1, 2'd0, 0);
    for (int i = 0; i < 260; i++) cycle(1, 8'(i), 1, 2'd0, 0);
    chk("sat_drop", 32'(drop_cnt), 255);

    // Randomized traffic in phases of differing drain pressure
    for (int ph = 0; ph < 4; ph++) begin
      rd_pct = (ph == 0) ? 60 : (ph == 1) ? 20 : (ph == 2) ? 45 : 5;
      for (int i = 0; i < 250; i++) begin
        rm = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 3)) : mo;
        cycle(1'($urandom_range(0, 19) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
              rm, 1'($urandom_range(0, 99) < rd_pct));
      end
    end

    // Drain and let the last read settle
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 0, mo, 1);
    cycle(0, 8'h00, 0, mo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hic_event_fifo.md
HIC_EVENT_FIFO -- requirements
Module: hic_event_fifo

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries; power of two, 4..16.
REQ-002 Parameter DW, 8, width of the captured counter value.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port arm, input, 1, capture enable from the host.
REQ-006 Port fout, input, DW, counter value from the upstream HIC stage.
REQ-007 Port cout, input, 1, carry/overflow strobe from the upstream HIC stage.
REQ-008 Port mo, input, 2, mode echo from the upstream HIC stage.
REQ-009 Port rd_req, input, 1, host pop request.
REQ-010 Port rd_data, output, DW+2, popped entry {mo, fout}.
REQ-011 Port rd_valid, output, 1, one-cycle strobe qualifying rd_data.
REQ-012 Port empty, output, 1, FIFO holds zero entries.
REQ-013 Port full, output, 1, FIFO holds DEPTH entries.
REQ-014 Port level, output, $clog2(DEPTH)+1, current entry count.
REQ-015 Port drop_cnt, output, 8, saturating count of lost events.
REQ-016 Port halted, output, 1, high while in state HALT.

Function
REQ-017 Event: cout==1, or mo differs from the previous-cycle registered mo (mo_q), sampled on the same edge.
REQ-018 FSM states: IDLE, RUN, HALT. IDLE->RUN when arm==1. RUN->IDLE when arm==0. RUN->HALT when an event finds full==1 with no pop in that cycle. HALT->IDLE when arm==0. HALT->RUN when level drops below DEPTH and arm==1.
REQ-019 Push only in RUN: an event writes {mo, fout} at the write pointer on the same edge.
REQ-020 Events in IDLE are ignored and do not count as drops.
REQ-021 Events in HALT, or in RUN with full and no pop, increment drop_cnt; drop_cnt saturates at 255.
REQ-022 Pop when rd_req==1 and empty==0; rd_data and rd_valid are registered, with a 1-cycle latency after the rd_req edge.
REQ-023 rd_req while empty: no pointer change, rd_valid=0, rd_data holds its previous value.
REQ-024 Simultaneous push and pop while full: both happen, level is unchanged, no drop.
REQ-025 Simultaneous push and pop while empty: push happens, pop ignored, level becomes 1.
REQ-026 Pointers wrap modulo DEPTH; full/empty are derived from level, never from pointer equality alone.
REQ-027 mo_q updates every cycle regardless of state.

Reset
REQ-028 On rst==0, immediately: state=IDLE, pointers=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, drop_cnt=0, halted=0, mo_q=2'b00.
REQ-029 Reset mid-operation discards all stored entries; memory contents need not be cleared.
REQ-030 First event detection after reset release compares against mo_q=2'b00.

Structure
REQ-031 Shared package hic_pkg holds the state encoding (IDLE=0, RUN=1, HALT=2), the mode constants (HOLD=0, UP=1, DOWN=2, LOAD=3) and the entry-width constant DW+2.
REQ-032 One sub-module, hic_fifo_mem: a DEPTH x (DW+2) register array with one write port and one read port; the FSM, pointers and counters live in the top module.

Verification
REQ-033 Reset with arm=1, mo=3, then change mo to 1 -> one entry {1, fout}; level=1; rd_req gives rd_valid=1 one cycle later with the matching data.
REQ-034 In RUN, pulse cout 8 times with fout=0x10..0x17 -> full=1, level=8; pops return 0x10..0x17 in order, then empty=1.
REQ-035 With the FIFO full, send 3 more cout pulses without rd_req -> halted=1, drop_cnt=3; pop one entry with arm=1 -> RUN, and the next cout is stored.
REQ-036 With the FIFO full, assert cout and rd_req on the same edge -> level stays 8, drop_cnt is unchanged, and the oldest entry appears on rd_data.
REQ-037 Assert rd_req while empty -> rd_valid stays 0 and no pointer change; with arm=0, toggle cout 5 times -> level=0, drop_cnt=0.
REQ-038 Assert rst low mid-burst with level=5 -> all outputs take their reset values asynchronously, before the next clk edge.
